dcache_refill_arbiter: RTL and testbench

Arbiter-side responder for the data-cache miss-repair protocol. It watches `read_repair_request`/`missed_addr` from the dCache controller, fetches the 1024-bit line from main memory as 32 word reads, then writes the line into the cache and pulses `repair_resolved`. While idle, it forwards core load requests onto the controller's read port.

---
 rtl/dcache_refill_arbiter.sv | 136 +++++++++++++
 tb/tb_dcache_refill_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_arbiter.sv
// Data-cache miss-repair responder: fetches a full line from memory as word reads,
// writes it into the cache, then pulses repair_resolved. Forwards core loads while idle.
module dcache_refill_arbiter #(
    parameter int LINE_WORDS      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_repair_request,
    input  logic [31:0]               missed_addr,
    output logic                      raddr_valid,
    output logic [31:0]               raddr,
    output logic                      rdata_valid,
    output logic                      waddr_valid,
    output logic [31:0]               waddr,
    output logic [LINE_WORDS*32-1:0]  wdata,
    output logic [LINE_WORDS*4-1:0]   wmask,
    output logic                      repair_resolved,
    input  logic                      core_rd_valid,
    input  logic [31:0]               core_rd_addr,
    output logic                      core_rd_stall,
    output logic                      mem_req,
    output logic [31:0]               mem_addr,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    output logic [2:0]                dbg_state
);

    localparam int          CW       = $clog2(LINE_WORDS + 1);
    localparam int          IW       = $clog2(LINE_WORDS);
    localparam logic [31:0] OFF_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WRITE   = 3'd2,
        RESOLVE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [31:0]                  base_q, base_d;
    logic [CW-1:0]                iss_q, iss_d;
    logic [CW-1:0]                rsp_q, rsp_d;
    logic [LINE_WORDS-1:0][31:0]  line_q, line_d;
    logic                         wr_strobe_q, wr_strobe_d;
    logic                         resolved_q, resolved_d;
    logic                         in_idle;
    logic                         issue;

    // Handshake: a memory read is transferred on a rising edge where mem_req && mem_ready;
    // mem_req/mem_addr depend only on registered state, so they hold until accepted.
    assign in_idle       = (state_q == IDLE);
    assign raddr_valid   = in_idle & core_rd_valid;
    assign raddr         = in_idle ? core_rd_addr : 32'd0;
    assign core_rd_stall = ~in_idle & core_rd_valid;
    assign rdata_valid   = 1'b0;

    assign mem_req  = (state_q == FETCH) &&
                      (iss_q < CW'(LINE_WORDS)) &&
                      ((iss_q - rsp_q) < CW'(MAX_OUTSTANDING));
    assign mem_addr = mem_req ? (base_q + 32'({iss_q, 2'b00})) : 32'd0;
    assign issue    = mem_req & mem_ready;

    // Write-side outputs lag the WRITE state by one edge; the line buffer is frozen then.
    assign waddr_valid     = wr_strobe_q;
    assign waddr           = wr_strobe_q ? base_q : 32'd0;
    assign wdata           = wr_strobe_q ? line_q : '0;
    assign wmask           = {(LINE_WORDS * 4){wr_strobe_q}};
    assign repair_resolved = resolved_q;
    assign dbg_state       = state_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        iss_d       = iss_q;
        rsp_d       = rsp_q;
        line_d      = line_q;
        wr_strobe_d = (state_q == WRITE);
        resolved_d  = (state_q == RESOLVE);

        case (state_q)
            IDLE: begin
                if (read_repair_request) begin
                    base_d  = missed_addr & ~OFF_MASK;
                    iss_d   = '0;
                    rsp_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    iss_d = iss_q + 1'b1;
                end
                if (mem_rvalid && (rsp_q < CW'(LINE_WORDS))) begin
                    line_d[rsp_q[IW-1:0]] = mem_rdata;
                    rsp_d                 = rsp_q + 1'b1;
                    if (rsp_q == CW'(LINE_WORDS - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE:   state_d = RESOLVE;
            RESOLVE: state_d = DRAIN;
            DRAIN: begin
                // Only a dropped request re-arms the miss detector.
                if (!read_repair_request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            iss_q       <= '0;
            rsp_q       <= '0;
            line_q      <= '0;
            wr_strobe_q <= 1'b0;
            resolved_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            iss_q       <= iss_d;
            rsp_q       <= rsp_d;
            line_q      <= line_d;
            wr_strobe_q <= wr_strobe_d;
            resolved_q  <= resolved_d;
        end
    end

endmodule

// File: tb/tb_dcache_refill_arbiter.sv
// Directed bench for dcache_refill_arbiter: forwarding table, full-line misses with
// varying memory timing, held request, and reset in the middle of a fetch.
module tb_dcache_refill_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_repair_request;
  logic [31:0]   missed_addr;
  logic          raddr_valid;
  logic [31:0]   raddr;
  logic          rdata_valid;
  logic          waddr_valid;
  logic [31:0]   waddr;
  logic [1023:0] wdata;
  logic [127:0]  wmask;
  logic          repair_resolved;
  logic          core_rd_valid;
  logic [31:0]   core_rd_addr;
  logic          core_rd_stall;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = 32'd0;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  dcache_refill_arbiter #(.LINE_WORDS(32), .MAX_OUTSTANDING(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .read_repair_request (read_repair_request),
    .missed_addr         (missed_addr),
    .raddr_valid         (raddr_valid),
    .raddr               (raddr),
    .rdata_valid         (rdata_valid),
    .waddr_valid         (waddr_valid),
    .waddr               (waddr),
    .wdata               (wdata),
    .wmask               (wmask),
    .repair_resolved     (repair_resolved),
    .core_rd_valid       (core_rd_valid),
    .core_rd_addr        (core_rd_addr),
    .core_rd_stall       (core_rd_stall),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ready           (mem_ready),
    .mem_rvalid          (mem_rvalid),
    .mem_rdata           (mem_rdata),
    .dbg_state           (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  rd_t         mq[$];
  logic [31:0] issued_q[$];

  int            cyc = 0;
  bit            bp_mode = 1'b0;
  int            lat = 1;
  bit            prev_stall = 1'b0;
  logic [31:0]   prev_addr = 32'd0;
  int            stab_err = 0;
  int            max_out = 0;
  int            wr_cnt = 0, wr_cyc = 0, res_cnt = 0, res_cyc = 0, overlap = 0;
  int            resp_seen = 0, fetch_start = -1;
  logic [31:0]   wr_addr = 32'd0;
  logic [1023:0] wr_data = '0;
  logic [127:0]  wr_mask = '0;
  bit            rdv_seen = 1'b0;
  logic [2:0]    prev_state = 3'd0;

  // Memory model and output monitor, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      mq.delete();
      mem_rvalid = 1'b0;
      mem_ready  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mq[0].addr;
        void'(mq.pop_front());
        resp_seen++;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
      end
      mem_ready = bp_mode ? ((cyc % 2) == 0) : 1'b1;
      if (prev_stall && (!mem_req || mem_addr !== prev_addr)) stab_err++;
      prev_stall = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      if (mem_req && mem_ready) begin
        mq.push_back('{mem_addr, cyc + lat});
        issued_q.push_back(mem_addr);
      end
      if (mq.size() + int'(mem_rvalid) > max_out) max_out = mq.size() + int'(mem_rvalid);
    end
    if (rdata_valid) rdv_seen = 1'b1;
    if (waddr_valid) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_addr = waddr;
      wr_data = wdata;
      wr_mask = wmask;
    end
    if (repair_resolved) begin
      res_cnt++;
      res_cyc = cyc;
      if (waddr_valid) overlap++;
    end
    if (dbg_state == 3'd1 && prev_state == 3'd0) fetch_start = cyc;
    prev_state = dbg_state;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_cnt      = 0;
    res_cnt     = 0;
    overlap     = 0;
    resp_seen   = 0;
    max_out     = 0;
    stab_err    = 0;
    fetch_start = -1;
    issued_q.delete();
  endtask

  task automatic wait_resolved(input string tag, input int budget);
    int n = 0;
    while (res_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_resolve_timeout"}, (res_cnt == 0) ? 64'd1 : 64'd0, 64'd0);
  endtask

  task automatic check_line(input string tag, input logic [31:0] base);
    int bad  = 0;
    int badi = 0;
    for (int i = 0; i < 32; i++) begin
      if (wr_data[32*i +: 32] !== base + 32'(4 * i)) bad++;
      if (i >= issued_q.size()) badi++;
      else if (issued_q[i] !== base + 32'(4 * i)) badi++;
    end
    chk({tag, "_wr_count"},    wr_cnt, 1);
    chk({tag, "_res_count"},   res_cnt, 1);
    chk({tag, "_res_follows"}, res_cyc - wr_cyc, 1);
    chk({tag, "_overlap"},     overlap, 0);
    chk({tag, "_waddr"},       wr_addr, base);
    chk({tag, "_wmask_ones"},  (wr_mask == {128{1'b1}}) ? 64'd1 : 64'd0, 64'd1);
    chk({tag, "_word0"},       wr_data[31:0], base);
    chk({tag, "_word31"},      wr_data[1023:992], base + 32'h7C);
    chk({tag, "_bad_words"},   bad, 0);
    chk({tag, "_issue_count"}, issued_q.size(), 32);
    chk({tag, "_issue_order"}, badi, 0);
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic        exp_rv;
    logic [31:0] exp_raddr;
    logic        exp_stall;
  } fwd_vec_t;

  fwd_vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 32'h1000_0040, 1'b1, 32'h1000_0040, 1'b0};
    vecs[1] = '{1'b0, 32'h1000_0040, 1'b0, 32'h1000_0040, 1'b0};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};

    rst                 = 1'b0;
    read_repair_request = 1'b0;
    missed_addr         = 32'd0;
    core_rd_valid       = 1'b0;
    core_rd_addr        = 32'd0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",       dbg_state, 3'd0);
    chk("rst_waddr_valid", waddr_valid, 0);
    chk("rst_resolved",    repair_resolved, 0);
    chk("rst_mem_req",     mem_req, 0);
    chk("rst_mem_addr",    mem_addr, 0);
    chk("rst_waddr",       waddr, 0);
    chk("rst_wdata",       (wdata == '0) ? 64'd1 : 64'd0, 64'd1);
    chk("rst_wmask",       wmask[63:0], 0);
    chk("rst_raddr_valid", raddr_valid, 0);
    chk("rst_stall",       core_rd_stall, 0);
    rst = 1'b1;
    tick();

    // Forwarding table in IDLE
    for (int i = 0; i < 5; i++) begin
      core_rd_valid = vecs[i].vld;
      core_rd_addr  = vecs[i].addr;
      #1;
      chk($sformatf("fwd%0d_rv", i),    raddr_valid,   vecs[i].exp_rv);
      chk($sformatf("fwd%0d_raddr", i), raddr,         vecs[i].exp_raddr);
      chk($sformatf("fwd%0d_stall", i), core_rd_stall, vecs[i].exp_stall);
    end
    core_rd_valid = 1'b0;
    core_rd_addr  = 32'd0;
    tick();

    // Basic miss, then request held past resolve
    clear_obs();
    missed_addr         = 32'hAABB_CCDD;
    read_repair_request = 1'b1;
    tick();
    chk("a_fetch_entered", dbg_state, 3'd1);
    missed_addr = 32'hDEAD_BEEF;
    repeat (4) tick();
    core_rd_valid = 1'b1;
    core_rd_addr  = 32'h1000_0040;
    #1;
    chk("a_fetch_raddr_valid", raddr_valid, 0);
    chk("a_fetch_stall",       core_rd_stall, 1);
    core_rd_valid = 1'b0;
    core_rd_addr  = 32'd0;
    wait_resolved("a", 200);
    check_line("a", 32'hAABB_CC80);
    chk("a_latency", wr_cyc - fetch_start, 34);
    repeat (3) tick();
    chk("held_state_drain", dbg_state, 3'd4);
    chk("held_no_refetch",  issued_q.size(), 32);
    chk("held_mem_req",     mem_req, 0);
    chk("held_wr_count",    wr_cnt, 1);
    read_repair_request = 1'b0;
    tick();
    chk("a_back_idle", dbg_state, 3'd0);
    tick();

    // Backpressure: ready toggles, 3-cycle read latency, request reasserted
    clear_obs();
    bp_mode             = 1'b1;
    lat                 = 3;
    missed_addr         = 32'hAABB_CCDD;
    read_repair_request = 1'b1;
    wait_resolved("b", 400);
    check_line("b", 32'hAABB_CC80);
    chk("b_max_out_ok",  (max_out <= 4) ? 64'd1 : 64'd0, 64'd1);
    chk("b_addr_stable", stab_err, 0);
    read_repair_request = 1'b0;
    repeat (2) tick();

    // Long latency saturates the outstanding limit
    clear_obs();
    bp_mode             = 1'b0;
    lat                 = 8;
    missed_addr         = 32'h0000_0104;
    read_repair_request = 1'b1;
    wait_resolved("c", 400);
    check_line("c", 32'h0000_0100);
    chk("c_max_out", max_out, 4);
    read_repair_request = 1'b0;
    repeat (2) tick();

    // Reset after 10 responses
    clear_obs();
    lat                 = 1;
    missed_addr         = 32'h1234_5678;
    read_repair_request = 1'b1;
    begin
      int n = 0;
      while (resp_seen < 10 && n < 100) begin
        tick();
        n++;
      end
      chk("r_resp_timeout", (resp_seen < 10) ? 64'd1 : 64'd0, 64'd0);
    end
    tick();
    rst = 1'b0;
    #1;
    chk("r_rst_state",   dbg_state, 3'd0);
    chk("r_rst_mem_req", mem_req, 0);
    chk("r_rst_waddr_v", waddr_valid, 0);
    read_repair_request = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("r_no_write",   wr_cnt, 0);
    chk("r_no_resolve", res_cnt, 0);
    clear_obs();
    read_repair_request = 1'b1;
    wait_resolved("r", 200);
    check_line("r", 32'h1234_5600);
    read_repair_request = 1'b0;
    repeat (2) tick();

    chk("rdata_valid_never", rdv_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
